// File: rtl/frame_pkg.sv
// Shared types, default geometry and address helper for the dual-port frame buffer.
package frame_pkg;

    typedef enum logic [0:0] {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_t;

    localparam int         DEF_WIDTH       = 64;
    localparam int         DEF_HEIGHT      = 48;
    localparam int         DEF_PIX_W       = 3;
    localparam logic [2:0] DEF_RESET_COLOR = 3'b010;

    // Linear pixel address: row-major, y*width + x, computed at full 32-bit width.
    function automatic logic [31:0] addr_of(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] width
    );
        return (y * width) + x;
    endfunction

endpackage

// File: rtl/frame_ram_dp.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// The storage array carries no reset so it can map onto block RAM / SRAM.
module frame_ram_dp #(
    parameter int DEPTH = 3072,
    parameter int PIX_W = 3,
    parameter int A_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [A_W-1:0]   waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [A_W-1:0]   raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_r [DEPTH];
    logic [PIX_W-1:0] rdata_r;

    // Array write; no reset on the storage itself.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; same-cycle write to the same address yields the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {PIX_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/frame_buffer_dp.sv
// Dual-port frame buffer: host write port with bounds checking and drop flag,
// a clear sequencer that fills the frame with a colour one pixel per cycle,
// and a scanout read port with out-of-range masking.
module frame_buffer_dp
    import frame_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               HEIGHT      = DEF_HEIGHT,
    parameter int               PIX_W       = DEF_PIX_W,
    parameter logic [PIX_W-1:0] RESET_COLOR = PIX_W'(DEF_RESET_COLOR),
    localparam int              X_W         = $clog2(WIDTH),
    localparam int              Y_W         = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             clear_req,
    input  logic [PIX_W-1:0] clear_color,
    input  logic             drop_clr,
    output logic             busy,
    output logic             wr_drop,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid
);

    localparam int             DEPTH    = WIDTH * HEIGHT;
    localparam int             A_W      = $clog2(DEPTH);
    localparam logic [A_W-1:0] LAST_PTR = A_W'(DEPTH - 1);

    fb_state_t        state_r;
    fb_state_t        state_next_s;
    logic [A_W-1:0]   clr_ptr_r;
    logic [PIX_W-1:0] fill_r;
    logic             busy_r;
    logic             wr_drop_r;
    logic             rd_valid_r;
    logic             rd_oor_r;

    logic             wr_in_range_s;
    logic             rd_in_range_s;
    logic [A_W-1:0]   wr_addr_s;
    logic [A_W-1:0]   rd_addr_s;

    logic             ram_we_s;
    logic [A_W-1:0]   ram_waddr_s;
    logic [PIX_W-1:0] ram_wdata_s;
    logic             ram_re_s;
    logic [PIX_W-1:0] ram_rdata_s;
    logic             drop_s;

    // Bounds checks and linear addresses; addresses are only used when in range.
    assign wr_in_range_s = (32'(wr_x) < 32'(WIDTH)) && (32'(wr_y) < 32'(HEIGHT));
    assign rd_in_range_s = (32'(rd_x) < 32'(WIDTH)) && (32'(rd_y) < 32'(HEIGHT));
    assign wr_addr_s     = A_W'(addr_of(32'(wr_x), 32'(wr_y), 32'(WIDTH)));
    assign rd_addr_s     = A_W'(addr_of(32'(rd_x), 32'(rd_y), 32'(WIDTH)));

    // FSM state register; reset always restarts the clear from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FB_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: the clear runs to the last address; clear_req only starts one from idle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FB_CLEAR: begin
                if (clr_ptr_r == LAST_PTR) begin
                    state_next_s = FB_IDLE;
                end else begin
                    state_next_s = FB_CLEAR;
                end
            end
            FB_IDLE: begin
                if (clear_req) begin
                    state_next_s = FB_CLEAR;
                end else begin
                    state_next_s = FB_IDLE;
                end
            end
            default: begin
                state_next_s = FB_CLEAR;
            end
        endcase
    end

    // FSM outputs: write-port mux (clear sequencer has priority) and drop detection.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {A_W{1'b0}};
        ram_wdata_s = {PIX_W{1'b0}};
        drop_s      = 1'b0;
        case (state_r)
            FB_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_ptr_r;
                ram_wdata_s = fill_r;
                drop_s      = wr_en;
            end
            FB_IDLE: begin
                if (clear_req) begin
                    drop_s = wr_en;
                end else if (wr_en && wr_in_range_s) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = wr_addr_s;
                    ram_wdata_s = wr_data;
                end else begin
                    drop_s = wr_en;
                end
            end
            default: begin
                drop_s = wr_en;
            end
        endcase
    end

    // Clear pointer and fill colour; fill is captured when a clear is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr_r <= {A_W{1'b0}};
            fill_r    <= RESET_COLOR;
        end else begin
            case (state_r)
                FB_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + {{(A_W-1){1'b0}}, 1'b1};
                end
                FB_IDLE: begin
                    if (clear_req) begin
                        clr_ptr_r <= {A_W{1'b0}};
                        fill_r    <= clear_color;
                    end
                end
                default: begin
                    clr_ptr_r <= {A_W{1'b0}};
                end
            endcase
        end
    end

    // Registered busy flag tracks the state the FSM is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b1;
        end else begin
            busy_r <= (state_next_s == FB_CLEAR);
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous drop_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_r <= 1'b0;
        end else if (drop_s) begin
            wr_drop_r <= 1'b1;
        end else if (drop_clr) begin
            wr_drop_r <= 1'b0;
        end
    end

    // Read-side flags: valid is a delayed rd_en, out-of-range flag follows accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_oor_r <= ~rd_in_range_s;
            end
        end
    end

    // Out-of-range reads never touch the array; their result is masked to zero.
    assign ram_re_s = rd_en && rd_in_range_s;

    frame_ram_dp #(
        .DEPTH (DEPTH),
        .PIX_W (PIX_W),
        .A_W   (A_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (rd_addr_s),
        .rdata (ram_rdata_s)
    );

    assign busy     = busy_r;
    assign wr_drop  = wr_drop_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_oor_r ? {PIX_W{1'b0}} : ram_rdata_s;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Directed self-checking bench for frame_buffer_dp (default geometry plus an 80x60x6 instance).
module tb_frame_buffer_dp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [5:0] wr_y;
    logic [2:0] wr_data;
    logic       clear_req;
    logic [2:0] clear_color;
    logic       drop_clr;
    logic       busy;
    logic       wr_drop;
    logic       rd_en;
    logic [5:0] rd_x;
    logic [5:0] rd_y;
    logic [2:0] rd_data;
    logic       rd_valid;

    logic       g_rst_n;
    logic       g_wr_en;
    logic [6:0] g_wr_x;
    logic [5:0] g_wr_y;
    logic [5:0] g_wr_data;
    logic       g_clear_req;
    logic [5:0] g_clear_color;
    logic       g_drop_clr;
    logic       g_busy;
    logic       g_wr_drop;
    logic       g_rd_en;
    logic [6:0] g_rd_x;
    logic [5:0] g_rd_y;
    logic [5:0] g_rd_data;
    logic       g_rd_valid;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    frame_buffer_dp dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
        .drop_clr(drop_clr), .busy(busy), .wr_drop(wr_drop), .rd_en(rd_en),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    frame_buffer_dp #(
        .WIDTH(80), .HEIGHT(60), .PIX_W(6), .RESET_COLOR(6'h2A)
    ) dut_g (
        .clk(clk), .rst_n(g_rst_n), .wr_en(g_wr_en), .wr_x(g_wr_x), .wr_y(g_wr_y),
        .wr_data(g_wr_data), .clear_req(g_clear_req), .clear_color(g_clear_color),
        .drop_clr(g_drop_clr), .busy(g_busy), .wr_drop(g_wr_drop), .rd_en(g_rd_en),
        .rd_x(g_rd_x), .rd_y(g_rd_y), .rd_data(g_rd_data), .rd_valid(g_rd_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int x, input int y, output logic [2:0] d, output logic v);
        rd_en = 1'b1;
        rd_x  = 6'(x);
        rd_y  = 6'(y);
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic do_write(input int x, input int y, input logic [2:0] d);
        wr_en   = 1'b1;
        wr_x    = 6'(x);
        wr_y    = 6'(y);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(output int edges);
        edges = 0;
        while (busy === 1'b1 && edges < 10000) begin
            tick();
            edges++;
        end
    endtask

    task automatic check_frame(input string name, input logic [2:0] exp);
        logic [2:0] d;
        logic       v;
        int         errs;
        errs = 0;
        for (int y = 0; y < 48; y++) begin
            for (int x = 0; x < 64; x++) begin
                do_read(x, y, d, v);
                if (d !== exp || v !== 1'b1) errs++;
            end
        end
        checks++;
        if (errs !== 0) $display("FAIL %s: %0d pixels differ from required %b", name, errs, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, wr_drop, rd_data, rd_valid} !== {1'b1, 1'b0, 3'b000, 1'b0})
            $display("FAIL reset_state: busy=%b wr_drop=%b rd_data=%b rd_valid=%b, required 1 0 000 0",
                     busy, wr_drop, rd_data, rd_valid);
        else passed++;
    endtask

    task automatic test_post_reset_clear();
        int         edges;
        logic [2:0] d;
        logic       v;
        rst_n = 1'b1;
        wait_idle(edges);
        checks++;
        if (edges !== 3072) $display("FAIL post_reset_busy_len: got %0d edges, required 3072", edges);
        else passed++;
        do_read(0, 0, d, v);
        checks++;
        if (d !== 3'b010 || v !== 1'b1) $display("FAIL read_0_0: got %b/%b, required 010/1", d, v);
        else passed++;
        do_read(63, 47, d, v);
        checks++;
        if (d !== 3'b010 || v !== 1'b1) $display("FAIL read_63_47: got %b/%b, required 010/1", d, v);
        else passed++;
        do_read(17, 9, d, v);
        checks++;
        if (d !== 3'b010 || v !== 1'b1) $display("FAIL read_17_9: got %b/%b, required 010/1", d, v);
        else passed++;
    endtask

    task automatic test_write_read();
        logic [2:0] d;
        logic       v;
        do_write(5, 3, 3'b101);
        do_read(5, 3, d, v);
        checks++;
        if (d !== 3'b101 || v !== 1'b1) $display("FAIL write_read_5_3: got %b/%b, required 101/1", d, v);
        else passed++;
        do_read(6, 3, d, v);
        checks++;
        if (d !== 3'b010 || v !== 1'b1) $display("FAIL neighbour_6_3: got %b/%b, required 010/1", d, v);
        else passed++;
        tick();
        checks++;
        if (rd_data !== 3'b010 || rd_valid !== 1'b0)
            $display("FAIL read_hold: got %b/%b, required 010/0", rd_data, rd_valid);
        else passed++;
        checks++;
        if (wr_drop !== 1'b0) $display("FAIL no_drop_in_range: wr_drop=%b, required 0", wr_drop);
        else passed++;
    endtask

    task automatic test_same_addr();
        logic [2:0] d;
        logic       v;
        wr_en = 1'b1; wr_x = 6'd10; wr_y = 6'd10; wr_data = 3'b110;
        rd_en = 1'b1; rd_x = 6'd10; rd_y = 6'd10;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_data !== 3'b010 || rd_valid !== 1'b1)
            $display("FAIL read_first: got %b/%b, required 010/1", rd_data, rd_valid);
        else passed++;
        do_read(10, 10, d, v);
        checks++;
        if (d !== 3'b110) $display("FAIL read_after_write: got %b, required 110", d);
        else passed++;
    endtask

    task automatic test_out_of_range();
        logic [2:0] d;
        logic       v;
        do_write(5, 50, 3'b111);
        checks++;
        if (wr_drop !== 1'b1) $display("FAIL oor_write_drop: wr_drop=%b, required 1", wr_drop);
        else passed++;
        do_read(5, 3, d, v);
        checks++;
        if (d !== 3'b101) $display("FAIL oor_no_change: got %b, required 101", d);
        else passed++;
        do_read(0, 48, d, v);
        checks++;
        if (d !== 3'b000 || v !== 1'b1) $display("FAIL oor_read: got %b/%b, required 000/1", d, v);
        else passed++;
        do_read(0, 0, d, v);
        checks++;
        if (d !== 3'b010) $display("FAIL read_after_oor: got %b, required 010", d);
        else passed++;
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        checks++;
        if (wr_drop !== 1'b0) $display("FAIL drop_clr: wr_drop=%b, required 0", wr_drop);
        else passed++;
    endtask

    task automatic test_clear_drop();
        int edges;
        int c0;
        wr_en = 1'b1; wr_x = 6'd1; wr_y = 6'd1; wr_data = 3'b111;
        clear_req = 1'b1; clear_color = 3'b001;
        tick();
        c0 = cyc;
        wr_en = 1'b0; clear_req = 1'b0; clear_color = 3'b000;
        checks++;
        if (busy !== 1'b1 || wr_drop !== 1'b1)
            $display("FAIL clear_accept: busy=%b wr_drop=%b, required 1 1", busy, wr_drop);
        else passed++;
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        checks++;
        if (wr_drop !== 1'b0) $display("FAIL drop_clr_mid_clear: wr_drop=%b, required 0", wr_drop);
        else passed++;
        do_write(2, 2, 3'b111);
        checks++;
        if (wr_drop !== 1'b1) $display("FAIL write_while_busy: wr_drop=%b, required 1", wr_drop);
        else passed++;
        wr_en = 1'b1; wr_x = 6'd3; wr_y = 6'd3; wr_data = 3'b111; drop_clr = 1'b1;
        tick();
        wr_en = 1'b0; drop_clr = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) $display("FAIL set_beats_clear: wr_drop=%b, required 1", wr_drop);
        else passed++;
        clear_req = 1'b1; clear_color = 3'b111;
        repeat (5) tick();
        clear_req = 1'b0;
        wait_idle(edges);
        checks++;
        if (cyc - c0 !== 3072) $display("FAIL clear_len_no_restart: got %0d edges, required 3072", cyc - c0);
        else passed++;
        check_frame("frame_after_clear", 3'b001);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        checks++;
        if (wr_drop !== 1'b0) $display("FAIL drop_clr_after: wr_drop=%b, required 0", wr_drop);
        else passed++;
    endtask

    task automatic test_reset_mid_clear();
        int         edges;
        logic [2:0] d;
        logic       v;
        clear_req = 1'b1; clear_color = 3'b100;
        tick();
        clear_req = 1'b0;
        repeat (1535) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL mid_reset_state: busy=%b rd_valid=%b, required 1 0", busy, rd_valid);
        else passed++;
        tick();
        rst_n = 1'b1;
        wait_idle(edges);
        checks++;
        if (edges !== 3072) $display("FAIL mid_reset_busy_len: got %0d edges, required 3072", edges);
        else passed++;
        do_read(0, 0, d, v);
        checks++;
        if (d !== 3'b010) $display("FAIL mid_reset_0_0: got %b, required 010", d);
        else passed++;
        do_read(63, 47, d, v);
        checks++;
        if (d !== 3'b010) $display("FAIL mid_reset_63_47: got %b, required 010", d);
        else passed++;
    endtask

    task automatic test_geometry();
        int edges;
        g_rst_n = 1'b0;
        tick();
        g_rst_n = 1'b1;
        edges = 0;
        while (g_busy === 1'b1 && edges < 10000) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 4800) $display("FAIL geom_busy_len: got %0d edges, required 4800", edges);
        else passed++;
        g_rd_en = 1'b1; g_rd_x = 7'd79; g_rd_y = 6'd59;
        tick();
        g_rd_en = 1'b0;
        checks++;
        if (g_rd_data !== 6'h2A || g_rd_valid !== 1'b1)
            $display("FAIL geom_read_79_59: got %h/%b, required 2a/1", g_rd_data, g_rd_valid);
        else passed++;
        g_wr_en = 1'b1; g_wr_x = 7'd90; g_wr_y = 6'd0; g_wr_data = 6'h15;
        tick();
        g_wr_en = 1'b0;
        checks++;
        if (g_wr_drop !== 1'b1) $display("FAIL geom_oor_x_drop: wr_drop=%b, required 1", g_wr_drop);
        else passed++;
        g_rd_en = 1'b1; g_rd_x = 7'd90; g_rd_y = 6'd1;
        tick();
        g_rd_en = 1'b0;
        checks++;
        if (g_rd_data !== 6'h00 || g_rd_valid !== 1'b1)
            $display("FAIL geom_oor_x_read: got %h/%b, required 00/1", g_rd_data, g_rd_valid);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_x = 6'd0; wr_y = 6'd0; wr_data = 3'd0;
        clear_req = 1'b0; clear_color = 3'd0; drop_clr = 1'b0;
        rd_en = 1'b0; rd_x = 6'd0; rd_y = 6'd0;
        g_rst_n = 1'b0; g_wr_en = 1'b0; g_wr_x = 7'd0; g_wr_y = 6'd0; g_wr_data = 6'd0;
        g_clear_req = 1'b0; g_clear_color = 6'd0; g_drop_clr = 1'b0;
        g_rd_en = 1'b0; g_rd_x = 7'd0; g_rd_y = 6'd0;
        #1;
        test_reset();
        test_post_reset_clear();
        test_write_read();
        test_same_addr();
        test_out_of_range();
        test_clear_drop();
        test_reset_mid_clear();
        test_geometry();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
